// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for a 5-stage MIPS-style pipeline: load-use/branch stall, forwarding selects
// and multiply/divide busy tracking (built only when HAZ_MDU_TRACK_EN is defined).
module pipe_hazard_ctrl #(
  parameter int unsigned AW      = 5,
  parameter int unsigned MUL_LAT = 5,
  parameter int unsigned DIV_LAT = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic          flush,
  input  logic [AW-1:0] rs_D,
  input  logic [AW-1:0] rt_D,
  input  logic [1:0]    tuse_rs_D,
  input  logic [1:0]    tuse_rt_D,
  input  logic [AW-1:0] a3_D,
  input  logic [1:0]    tnew_D,
  input  logic [1:0]    md_op_D,
  input  logic          md_use_D,
  output logic          stall,
  output logic [1:0]    fwd_rs_D,
  output logic [1:0]    fwd_rt_D,
  output logic [1:0]    fwd_rs_E,
  output logic [1:0]    fwd_rt_E,
  output logic          fwd_rt_M,
  output logic [AW-1:0] a3_W,
  output logic          md_busy
);

  typedef struct packed {
    logic [AW-1:0] a3;
    logic [1:0]    tnew;
    logic [AW-1:0] rs;
    logic [AW-1:0] rt;
  } stage_t;

  stage_t e_q, m_q, w_q, e_d, m_d, w_d;
  logic   md_stall;
  logic   advance;
  logic   unused_w_src;

  function automatic stage_t age(input stage_t s);
    stage_t r = s;
    if (r.tnew != 2'd0) r.tnew = r.tnew - 2'd1;
    return r;
  endfunction

  // Only the nearest writer in E/M matters; an older writer is shadowed by it.
  function automatic logic src_stall(input logic [AW-1:0] s, input logic [1:0] tuse,
                                     input stage_t e, input stage_t m);
    logic hit = 1'b0;
    if (tuse != 2'd3 && s != '0) begin
      if (e.a3 == s)      hit = (e.tnew > tuse);
      else if (m.a3 == s) hit = (m.tnew > tuse);
    end
    return hit;
  endfunction

  function automatic logic [1:0] src_fwd_d(input logic [AW-1:0] s, input logic [1:0] tuse,
                                           input stage_t e, input stage_t m, input stage_t w);
    logic [1:0] sel = 2'd0;
    if (tuse != 2'd3 && s != '0) begin
      if (e.a3 == s)      sel = (e.tnew == 2'd0) ? 2'd1 : 2'd0;
      else if (m.a3 == s) sel = (m.tnew == 2'd0) ? 2'd2 : 2'd0;
      else if (w.a3 == s) sel = (w.tnew == 2'd0) ? 2'd3 : 2'd0;
    end
    return sel;
  endfunction

  function automatic logic [1:0] src_fwd_e(input logic [AW-1:0] s, input stage_t m,
                                           input stage_t w);
    logic [1:0] sel = 2'd0;
    if (s != '0) begin
      if (m.a3 == s && m.tnew == 2'd0) sel = 2'd1;
      else if (w.a3 == s)              sel = 2'd2;
    end
    return sel;
  endfunction

  assign stall = src_stall(rs_D, tuse_rs_D, e_q, m_q) | src_stall(rt_D, tuse_rt_D, e_q, m_q) |
                 md_stall;
  assign advance = en & ~flush & ~stall;

  assign fwd_rs_D = src_fwd_d(rs_D, tuse_rs_D, e_q, m_q, w_q);
  assign fwd_rt_D = src_fwd_d(rt_D, tuse_rt_D, e_q, m_q, w_q);
  assign fwd_rs_E = src_fwd_e(e_q.rs, m_q, w_q);
  assign fwd_rt_E = src_fwd_e(e_q.rt, m_q, w_q);
  assign fwd_rt_M = (m_q.rt != '0) && (w_q.a3 == m_q.rt);
  assign a3_W     = w_q.a3;

  assign unused_w_src = ^{w_q.rs, w_q.rt};

  // flush wins over stall: both E and M become bubbles while W still drains.
  always_comb begin
    e_d = e_q;
    m_d = m_q;
    w_d = w_q;
    if (en) begin
      w_d = age(m_q);
      m_d = flush ? '0 : age(e_q);
      e_d = advance ? '{a3: a3_D, tnew: tnew_D, rs: rs_D, rt: rt_D} : '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      e_q <= '0;
      m_q <= '0;
      w_q <= '0;
    end else begin
      e_q <= e_d;
      m_q <= m_d;
      w_q <= w_d;
    end
  end

`ifdef HAZ_MDU_TRACK_EN
  localparam logic [7:0] MulLat = 8'(MUL_LAT);
  localparam logic [7:0] DivLat = 8'(DIV_LAT);

  logic [1:0] md_op_e_q, md_op_e_d, md_op_m_q, md_op_m_d;
  logic [7:0] md_cnt_q, md_cnt_d;
  logic       unused_md_op_m;

  // The count keeps running through a flush; only reset stops it.
  always_comb begin
    md_op_e_d = md_op_e_q;
    md_op_m_d = md_op_m_q;
    md_cnt_d  = md_cnt_q;
    if (en) begin
      md_op_m_d = flush ? 2'd0 : md_op_e_q;
      md_op_e_d = advance ? md_op_D : 2'd0;
      if (advance && md_op_D == 2'd1)      md_cnt_d = MulLat;
      else if (advance && md_op_D == 2'd2) md_cnt_d = DivLat;
      else if (md_cnt_q != 8'd0)           md_cnt_d = md_cnt_q - 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      md_op_e_q <= 2'd0;
      md_op_m_q <= 2'd0;
      md_cnt_q  <= 8'd0;
    end else begin
      md_op_e_q <= md_op_e_d;
      md_op_m_q <= md_op_m_d;
      md_cnt_q  <= md_cnt_d;
    end
  end

  assign md_busy        = (md_cnt_q != 8'd0) | (md_op_e_q != 2'd0);
  assign md_stall       = md_use_D & md_busy;
  assign unused_md_op_m = ^md_op_m_q;
`else
  logic unused_md_in;
  assign unused_md_in = ^{md_op_D, md_use_D};
  assign md_busy      = 1'b0;
  assign md_stall     = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed vector table, hand-written corner sequences
// and randomized stimulus against a stage-index reference model.
module tb_pipe_hazard_ctrl;

  localparam int AW      = 5;
  localparam int MUL_LAT = 5;
  localparam int DIV_LAT = 10;
`ifdef HAZ_MDU_TRACK_EN
  localparam bit MduOn = 1'b1;
`else
  localparam bit MduOn = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset, en, flush;
  logic [AW-1:0] rs_D, rt_D, a3_D;
  logic [1:0]    tuse_rs_D, tuse_rt_D, tnew_D, md_op_D;
  logic          md_use_D;
  logic          stall, fwd_rt_M, md_busy;
  logic [1:0]    fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E;
  logic [AW-1:0] a3_W;

  pipe_hazard_ctrl #(.AW(AW), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk(clk), .reset(reset), .en(en), .flush(flush),
    .rs_D(rs_D), .rt_D(rt_D), .tuse_rs_D(tuse_rs_D), .tuse_rt_D(tuse_rt_D),
    .a3_D(a3_D), .tnew_D(tnew_D), .md_op_D(md_op_D), .md_use_D(md_use_D),
    .stall(stall), .fwd_rs_D(fwd_rs_D), .fwd_rt_D(fwd_rt_D),
    .fwd_rs_E(fwd_rs_E), .fwd_rt_E(fwd_rt_E), .fwd_rt_M(fwd_rt_M),
    .a3_W(a3_W), .md_busy(md_busy)
  );

  always #5 clk = ~clk;

  int errors   = 0;
  int n_checks = 0;

  // Reference model: in-flight instructions by stage index (0=E, 1=M, 2=W). An instruction's
  // remaining latency is its entry tnew minus how many stages it has moved past E.
  typedef struct {int a3; int rs; int rt; int tnew0; int md_op;} minst_t;
  minst_t mp[3];
  int     ec;        // enabled edges since reset
  int     mdu_done;  // MDU free once ec reaches this

  function automatic int eff_tnew(int k);
    return (mp[k].tnew0 > k) ? mp[k].tnew0 - k : 0;
  endfunction

  function automatic int nearest(int s, int tuse);
    if (s == 0 || tuse == 3) return -1;
    for (int k = 0; k < 3; k++) if (mp[k].a3 == s) return k;
    return -1;
  endfunction

  function automatic bit m_busy();
    return MduOn && ((ec < mdu_done) || (mp[0].md_op != 0));
  endfunction

  function automatic bit m_src_stall(int s, int tuse);
    int k = nearest(s, tuse);
    return (k >= 0) && (k < 2) && (eff_tnew(k) > tuse);
  endfunction

  function automatic bit m_stall();
    return m_src_stall(int'(rs_D), int'(tuse_rs_D)) || m_src_stall(int'(rt_D), int'(tuse_rt_D))
           || (md_use_D && m_busy());
  endfunction

  function automatic int m_fwd_d(int s, int tuse);
    int k = nearest(s, tuse);
    return (k >= 0 && eff_tnew(k) == 0) ? k + 1 : 0;
  endfunction

  function automatic int m_fwd_e(int s);
    if (s == 0) return 0;
    if (mp[1].a3 == s && eff_tnew(1) == 0) return 1;
    if (mp[2].a3 == s) return 2;
    return 0;
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 3; k++) mp[k] = '{0, 0, 0, 0, 0};
    ec       = 0;
    mdu_done = 0;
  endfunction

  function automatic void model_step();
    bit adv;
    if (!en) return;
    adv   = !flush && !m_stall();
    mp[2] = mp[1];
    mp[1] = flush ? '{0, 0, 0, 0, 0} : mp[0];
    mp[0] = adv ? '{int'(a3_D), int'(rs_D), int'(rt_D), int'(tnew_D), int'(md_op_D)}
                : '{0, 0, 0, 0, 0};
    ec++;
    if (adv && md_op_D == 2'd1) mdu_done = ec + MUL_LAT;
    if (adv && md_op_D == 2'd2) mdu_done = ec + DIV_LAT;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, "_stall"}, int'(stall), int'(m_stall()));
    check({tag, "_fwd_rs_D"}, int'(fwd_rs_D), m_fwd_d(int'(rs_D), int'(tuse_rs_D)));
    check({tag, "_fwd_rt_D"}, int'(fwd_rt_D), m_fwd_d(int'(rt_D), int'(tuse_rt_D)));
    check({tag, "_fwd_rs_E"}, int'(fwd_rs_E), m_fwd_e(mp[0].rs));
    check({tag, "_fwd_rt_E"}, int'(fwd_rt_E), m_fwd_e(mp[0].rt));
    check({tag, "_fwd_rt_M"}, int'(fwd_rt_M), int'(mp[1].rt != 0 && mp[2].a3 == mp[1].rt));
    check({tag, "_a3_W"}, int'(a3_W), mp[2].a3);
    check({tag, "_md_busy"}, int'(md_busy), int'(m_busy()));
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_stall"}, int'(stall), 0);
    check({tag, "_fwd_D"}, int'({fwd_rs_D, fwd_rt_D}), 0);
    check({tag, "_fwd_E"}, int'({fwd_rs_E, fwd_rt_E}), 0);
    check({tag, "_fwd_rt_M"}, int'(fwd_rt_M), 0);
    check({tag, "_a3_W"}, int'(a3_W), 0);
    check({tag, "_md_busy"}, int'(md_busy), 0);
  endtask

  task automatic set_d(input int rs, input int tu_rs, input int rt, input int tu_rt, input int a3,
                       input int tnew, input int mdop, input int mduse);
    rs_D      = AW'(rs);
    tuse_rs_D = 2'(tu_rs);
    rt_D      = AW'(rt);
    tuse_rt_D = 2'(tu_rt);
    a3_D      = AW'(a3);
    tnew_D    = 2'(tnew);
    md_op_D   = 2'(mdop);
    md_use_D  = 1'(mduse);
    #1;
  endtask

  task automatic step();
    if (reset) model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic count_stalls(input string name, input int exp);
    int cnt = 0;
    for (int i = 0; i < 40 && stall; i++) begin
      cnt++;
      step();
    end
    check(name, cnt, exp);
  endtask

  typedef struct {
    int rs, tu_rs, rt, tu_rt, a3, tnew;
    int e_stall, e_frs_d, e_frt_d, e_frs_e, e_frt_e, e_frt_m, e_a3w;
  } vec_t;
  vec_t vecs[15];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // rs tu rt tu a3 tnew | stall frsD frtD frsE frtE frtM a3W
    vecs[0]  = '{1, 1, 0, 3, 8, 2,    0, 0, 0, 0, 0, 0, 0};   // lw $8
    vecs[1]  = '{8, 1, 2, 1, 10, 1,   1, 0, 0, 0, 0, 0, 0};   // addu uses $8: load-use
    vecs[2]  = '{8, 1, 2, 1, 10, 1,   0, 0, 0, 0, 0, 0, 0};
    vecs[3]  = '{10, 0, 8, 0, 0, 0,   1, 0, 3, 2, 0, 0, 8};   // beq on fresh ALU result
    vecs[4]  = '{10, 0, 8, 0, 0, 0,   0, 2, 0, 0, 0, 0, 0};
    vecs[5]  = '{10, 1, 10, 2, 0, 0,  0, 3, 3, 2, 0, 0, 10};
    vecs[6]  = '{0, 1, 0, 1, 0, 1,    0, 0, 0, 0, 0, 0, 0};   // writes $0
    vecs[7]  = '{0, 0, 0, 0, 5, 1,    0, 0, 0, 0, 0, 0, 0};   // reads $0
    vecs[8]  = '{5, 1, 0, 3, 6, 1,    0, 0, 0, 0, 0, 0, 0};
    vecs[9]  = '{6, 1, 6, 2, 0, 0,    0, 0, 0, 1, 0, 0, 0};
    vecs[10] = '{0, 3, 0, 3, 0, 0,    0, 0, 0, 1, 1, 0, 5};
    vecs[11] = '{0, 3, 0, 3, 0, 0,    0, 0, 0, 0, 0, 1, 6};
    vecs[12] = '{0, 3, 0, 3, 31, 0,   0, 0, 0, 0, 0, 0, 0};   // jal
    vecs[13] = '{31, 0, 0, 3, 0, 0,   0, 1, 0, 0, 0, 0, 0};   // jr $31 straight from E
    vecs[14] = '{0, 3, 0, 3, 0, 0,    0, 0, 0, 1, 0, 0, 0};

    reset = 1'b0;
    en    = 1'b1;
    flush = 1'b0;
    model_reset();
    set_d(8, 0, 8, 0, 8, 2, 2, 1);
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset_hold");
    reset = 1'b1;

    // Directed vector table from an empty pipeline.
    for (int i = 0; i < 15; i++) begin
      set_d(vecs[i].rs, vecs[i].tu_rs, vecs[i].rt, vecs[i].tu_rt, vecs[i].a3, vecs[i].tnew, 0, 0);
      check($sformatf("vec%0d_stall", i), int'(stall), vecs[i].e_stall);
      check($sformatf("vec%0d_fwd_rs_D", i), int'(fwd_rs_D), vecs[i].e_frs_d);
      check($sformatf("vec%0d_fwd_rt_D", i), int'(fwd_rt_D), vecs[i].e_frt_d);
      check($sformatf("vec%0d_fwd_rs_E", i), int'(fwd_rs_E), vecs[i].e_frs_e);
      check($sformatf("vec%0d_fwd_rt_E", i), int'(fwd_rt_E), vecs[i].e_frt_e);
      check($sformatf("vec%0d_fwd_rt_M", i), int'(fwd_rt_M), vecs[i].e_frt_m);
      check($sformatf("vec%0d_a3_W", i), int'(a3_W), vecs[i].e_a3w);
      step();
    end

    // div then mflo, mult then mflo, and a flush that must not cancel a running divide.
    do_reset();
    set_d(0, 3, 0, 3, 0, 0, 2, 0);
    step();
    set_d(0, 3, 0, 3, 9, 1, 0, 1);
    check("div_busy", int'(md_busy), int'(MduOn));
    count_stalls("div_stall_cycles", MduOn ? DIV_LAT : 0);
    check("div_done_busy", int'(md_busy), 0);
    set_d(0, 3, 0, 3, 0, 0, 1, 0);
    step();
    set_d(0, 3, 0, 3, 9, 1, 0, 1);
    count_stalls("mul_stall_cycles", MduOn ? MUL_LAT : 0);
    set_d(0, 3, 0, 3, 0, 0, 2, 0);
    step();
    flush = 1'b1;
    set_d(0, 3, 0, 3, 0, 0, 0, 0);
    step();
    flush = 1'b0;
    set_d(0, 3, 0, 3, 9, 1, 0, 1);
    count_stalls("div_after_flush_cycles", MduOn ? DIV_LAT - 1 : 0);

    // Reset mid-MDU-count clears busy at once.
    set_d(0, 3, 0, 3, 0, 0, 2, 0);
    step();
    set_d(0, 3, 0, 3, 9, 1, 0, 1);
    check("mdu_pre_reset_stall", int'(stall), int'(MduOn));
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check_zero("mdu_mid_reset");
    @(posedge clk);
    #1;
    reset = 1'b1;

    // flush coinciding with a load-use stall kills both E and M.
    set_d(1, 1, 0, 3, 7, 1, 0, 0);
    step();
    set_d(1, 1, 0, 3, 8, 2, 0, 0);
    step();
    set_d(8, 1, 0, 3, 10, 1, 0, 0);
    flush = 1'b1;
    #1;
    check("flush_stall_same_cycle", int'(stall), 1);
    step();
    flush = 1'b0;
    #1;
    check("post_flush_stall", int'(stall), 0);
    check("post_flush_fwd_rs_D", int'(fwd_rs_D), 0);
    check("post_flush_a3_W", int'(a3_W), 7);
    set_d(0, 3, 0, 3, 0, 0, 0, 0);
    step();
    check("post_flush_killed_a3_W", int'(a3_W), 0);

    // en=0 freezes a load-use stall; async reset mid-sequence; normal load after release.
    do_reset();
    set_d(1, 1, 0, 3, 3, 1, 0, 0);
    step();
    set_d(1, 1, 0, 3, 7, 1, 0, 0);
    step();
    set_d(1, 1, 0, 3, 8, 2, 0, 0);
    step();
    set_d(8, 1, 0, 3, 10, 1, 0, 0);
    check("freeze_pre_stall", int'(stall), 1);
    check("freeze_pre_a3_W", int'(a3_W), 3);
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("freeze%0d_stall", i), int'(stall), 1);
      check($sformatf("freeze%0d_a3_W", i), int'(a3_W), 3);
    end
    en = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check_zero("freeze_mid_reset");
    step();
    check_zero("freeze_reset_edge");
    reset = 1'b1;
    set_d(1, 1, 0, 3, 8, 2, 0, 0);
    step();
    set_d(8, 1, 0, 3, 10, 1, 0, 0);
    check("release_load_stall", int'(stall), 1);

    // Randomized traffic over a small register set against the reference model.
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
      en    = ($urandom_range(0, 9) != 0);
      flush = ($urandom_range(0, 9) == 0);
      set_d($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2),
            ($urandom_range(0, 11) == 0) ? $urandom_range(1, 2) : 0,
            ($urandom_range(0, 3) == 0) ? 1 : 0);
      if (!reset) model_reset();
      check_model($sformatf("rand%0d", i));
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, n_checks);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter AW, default 5: register-address width.
REQ-002 Parameter MUL_LAT, default 5: multiply busy cycles; DIV_LAT, default 10: divide busy cycles; both SHALL be within 1..255.
REQ-003 clk  in  1  sole clock, rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 en  in  1  pipeline advance; 0 freezes all internal state.
REQ-006 flush  in  1  exception flush; kills instructions entering or in E and M.
REQ-007 rs_D, rt_D  in  AW each  source addresses of the D instruction.
REQ-008 tuse_rs_D, tuse_rt_D  in  2 each  cycles until the operand is needed; 3 = unused.
REQ-009 a3_D  in  AW  destination address; 0 = no write.
REQ-010 tnew_D  in  2  cycles after E entry until the result exists (jal 0, ALU 1, load 2).
REQ-011 md_op_D  in  2  0 none, 1 mult, 2 div; md_use_D  in  1  the D instruction touches HI/LO.
REQ-012 stall  out  1  hold F/D and insert a bubble into E.
REQ-013 fwd_rs_D, fwd_rt_D  out  2 each  0 regfile, 1 E, 2 M, 3 W.
REQ-014 fwd_rs_E, fwd_rt_E  out  2 each  0 pipeline value, 1 M, 2 W; fwd_rt_M  out  1  0 pipeline value, 1 W.
REQ-015 a3_W  out  AW  W-stage destination; md_busy  out  1  MDU occupied.

Function
REQ-016 Stages E, M and W SHALL each hold {a3, tnew, rs, rt}; E and M SHALL additionally hold md_op.
REQ-017 When en=1, stall=0 and flush=0, E SHALL load the D fields and M/W SHALL shift, with tnew = max(tnew-1, 0) on each shift.
REQ-018 When en=1 and stall=1, E SHALL load a bubble (all fields 0) while M/W shift.
REQ-019 When en=1 and flush=1, E and M SHALL load bubbles and W SHALL shift; flush SHALL override stall.
REQ-020 When en=0, no register SHALL change, and outputs SHALL remain combinational on the current state.
REQ-021 A source s with tuse_s != 3 and s != 0 is matched by stage X iff a3_X == s; the E match SHALL take precedence over M, and M over W.
REQ-022 stall SHALL be 1 if the nearest matching stage among E/M has tnew > tuse_s for either source.
REQ-023 fwd_*_D SHALL select the nearest matching stage with tnew == 0, else 0.
REQ-024 fwd_*_E SHALL select M if a3_M == rs_E/rt_E (nonzero) and tnew_M == 0, else W on match, else 0.
REQ-025 fwd_rt_M SHALL be 1 iff a3_W == rt_M and rt_M != 0.
REQ-026 Address 0 SHALL never match, stall or forward.
REQ-027 MDU counter (8 bits): on E entry of md_op 1/2, load MUL_LAT/DIV_LAT; otherwise decrement by 1 per en=1 cycle while nonzero.
REQ-028 md_busy SHALL be (counter != 0) OR (md_op_E != 0); when md_use_D=1 and md_busy=1, stall SHALL be 1.
REQ-029 flush SHALL NOT cancel a running MDU count.
REQ-030 All outputs SHALL be combinational from the current state and D inputs; stall latency SHALL be 0 cycles.

Reset
REQ-031 While reset=0, all stage fields and the MDU counter SHALL be 0, giving stall=0, all fwd=0, a3_W=0 and md_busy=0, regardless of en.
REQ-032 Reset assertion mid-stall or mid-MDU-count SHALL clear immediately; the first en=1 edge after release SHALL load E normally.

Configuration
REQ-033 Macro HAZ_MDU_TRACK_EN defined: REQ-027..029 are implemented.
REQ-034 Macro HAZ_MDU_TRACK_EN undefined: no counter is built, md_op_D and md_use_D are ignored, and md_busy is tied 0; the port list is unchanged.

Verification
REQ-035 lw $8 (a3=8, tnew=2), then addu using rs=8 with tuse=1 -> stall=1 for 1 cycle, then fwd_rs_D=0 with a3_W=8 and fwd_rs_E=2 in the next cycle.
REQ-036 addu $9 (tnew=1), then beq rs=9 (tuse=0) -> stall=1 for 1 cycle, then fwd_rs_D=2 (M).
REQ-037 Instruction writing $0 followed by a consumer of $0 -> stall=0 and all fwd=0.
REQ-038 div enters E with DIV_LAT=10; mflo (md_use_D=1) follows -> stall=1 for exactly 10 cycles; without the macro, stall=0.
REQ-039 flush=1 and stall=1 in the same cycle -> E and M become bubbles; the next cycle shows stall=0 and fwd=0 for the killed destinations.
REQ-040 en=0 for 3 cycles during a load-use stall -> the stall value and a3_W are unchanged; reset=0 mid-sequence -> all outputs are 0 immediately.
